// File: rtl/pid_pkg.sv
// Shared definitions for the PID sample sequencer: FSM state encoding and
// coefficient select constants used by the coefficient bank and config bus.
package pid_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_TICK,
        ST_ADC_REQ,
        ST_PID_START,
        ST_PID_RUN
    } seq_state_t;

    localparam int unsigned NUM_COEFFS     = 5;
    localparam int unsigned COEFF_SEL_BITS = 3;

    localparam logic [COEFF_SEL_BITS-1:0] COEFF_A1 = 3'd0;
    localparam logic [COEFF_SEL_BITS-1:0] COEFF_A0 = 3'd1;
    localparam logic [COEFF_SEL_BITS-1:0] COEFF_B0 = 3'd2;
    localparam logic [COEFF_SEL_BITS-1:0] COEFF_B1 = 3'd3;
    localparam logic [COEFF_SEL_BITS-1:0] COEFF_B2 = 3'd4;

endpackage

// File: rtl/pid_tick_gen.sv
// Sample period tick generator.
// Counts clock cycles while enabled (held at 0 otherwise) and emits a
// one-cycle tick each time the count wraps after SAMPLE_PERIOD cycles.
// Ports:
//   clk    in  clock
//   rst    in  asynchronous active-high reset
//   enable in  count enable; low clears the counter
//   tick   out one-cycle pulse, once per SAMPLE_PERIOD enabled cycles
module pid_tick_gen #(
    parameter int unsigned PERIOD_BITWIDTH = 16,
    parameter int unsigned SAMPLE_PERIOD   = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic tick
);

    localparam logic [PERIOD_BITWIDTH-1:0] LAST_COUNT = PERIOD_BITWIDTH'(SAMPLE_PERIOD - 1);

    logic [PERIOD_BITWIDTH-1:0] count;
    logic                       tick_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= '0;
            tick_q <= 1'b0;
        end else if (!enable) begin
            count  <= '0;
            tick_q <= 1'b0;
        end else if (count == LAST_COUNT) begin
            count  <= '0;
            tick_q <= 1'b1;
        end else begin
            count  <= count + PERIOD_BITWIDTH'(1);
            tick_q <= 1'b0;
        end
    end

    // Gate with enable so a tick registered just before disable is not seen.
    assign tick = tick_q & enable;

endmodule

// File: rtl/pid_sample_sequencer.sv
// Fan-control PID sample sequencer.
// Per sample period: waits for a tick, requests an ADC conversion, latches
// the sample, pulses clk_en_PID_o and waits for PID_done_i. Also owns the
// five PID coefficients as a shadow/active pair; active only updates while
// no update is in flight (IDLE or WAIT_TICK).
// Ports:
//   clk_i, rst_i                 clock, async active-high reset
//   enable_i                     run sequencer
//   ADC_req_o / ADC_ack_i        conversion request level / ack strobe
//   ADC_data_i / ADC_value_o     conversion result / held sample
//   clk_en_PID_o / PID_done_i    PID start pulse / PID finished strobe
//   coeff_wr_i, coeff_sel_i,
//   coeff_data_i, coeff_commit_i shadow write and shadow->active commit
//   a1_reg_o..b2_reg_o           active coefficients
//   busy_o                       update in progress
//   overrun_o, timeout_o         sticky error flags
//   clear_flags_i                clears sticky flags
module pid_sample_sequencer
    import pid_pkg::*;
#(
    parameter int unsigned ADC_BITWIDTH    = 8,
    parameter int unsigned REG_BITWIDTH    = 32,
    parameter int unsigned PERIOD_BITWIDTH = 16,
    parameter int unsigned SAMPLE_PERIOD   = 50000,
    parameter int unsigned ADC_TIMEOUT     = 255
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      enable_i,
    output logic                      ADC_req_o,
    input  logic                      ADC_ack_i,
    input  logic [ADC_BITWIDTH-1:0]   ADC_data_i,
    output logic [ADC_BITWIDTH-1:0]   ADC_value_o,
    output logic                      clk_en_PID_o,
    input  logic                      PID_done_i,
    input  logic                      coeff_wr_i,
    input  logic [2:0]                coeff_sel_i,
    input  logic [REG_BITWIDTH-1:0]   coeff_data_i,
    input  logic                      coeff_commit_i,
    output logic [REG_BITWIDTH-1:0]   a1_reg_o,
    output logic [REG_BITWIDTH-1:0]   a0_reg_o,
    output logic [REG_BITWIDTH-1:0]   b0_reg_o,
    output logic [REG_BITWIDTH-1:0]   b1_reg_o,
    output logic [REG_BITWIDTH-1:0]   b2_reg_o,
    output logic                      busy_o,
    output logic                      overrun_o,
    output logic                      timeout_o,
    input  logic                      clear_flags_i
);

    localparam int unsigned TO_BITS = $clog2(ADC_TIMEOUT + 1);
    localparam logic [TO_BITS-1:0] TO_LAST = TO_BITS'(ADC_TIMEOUT - 1);

    seq_state_t                state;
    logic [TO_BITS-1:0]        to_count;
    logic                      tick;
    logic                      overrun_set;
    logic                      timeout_set;
    logic                      commit_window;
    logic                      pending;
    logic [REG_BITWIDTH-1:0]   shadow      [NUM_COEFFS];
    logic [REG_BITWIDTH-1:0]   shadow_next [NUM_COEFFS];
    logic [REG_BITWIDTH-1:0]   active      [NUM_COEFFS];

    pid_tick_gen #(
        .PERIOD_BITWIDTH (PERIOD_BITWIDTH),
        .SAMPLE_PERIOD   (SAMPLE_PERIOD)
    ) u_tick_gen (
        .clk    (clk_i),
        .rst    (rst_i),
        .enable (enable_i),
        .tick   (tick)
    );

    assign overrun_set = tick && (state != ST_WAIT_TICK);
    // Ack and disable both pre-empt the timeout in the same cycle.
    assign timeout_set = (state == ST_ADC_REQ) && !ADC_ack_i && enable_i && (to_count == TO_LAST);
    assign commit_window = (state == ST_IDLE) || (state == ST_WAIT_TICK);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= ST_IDLE;
            to_count     <= '0;
            ADC_req_o    <= 1'b0;
            ADC_value_o  <= '0;
            clk_en_PID_o <= 1'b0;
            busy_o       <= 1'b0;
            overrun_o    <= 1'b0;
            timeout_o    <= 1'b0;
        end else begin
            // Set wins over clear.
            if (overrun_set)        overrun_o <= 1'b1;
            else if (clear_flags_i) overrun_o <= 1'b0;
            if (timeout_set)        timeout_o <= 1'b1;
            else if (clear_flags_i) timeout_o <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (enable_i) state <= ST_WAIT_TICK;
                end
                ST_WAIT_TICK: begin
                    if (!enable_i) begin
                        state <= ST_IDLE;
                    end else if (tick) begin
                        state     <= ST_ADC_REQ;
                        ADC_req_o <= 1'b1;
                        busy_o    <= 1'b1;
                        to_count  <= '0;
                    end
                end
                ST_ADC_REQ: begin
                    if (ADC_ack_i) begin
                        state        <= ST_PID_START;
                        ADC_req_o    <= 1'b0;
                        ADC_value_o  <= ADC_data_i;
                        clk_en_PID_o <= 1'b1;
                    end else if (!enable_i) begin
                        state     <= ST_IDLE;
                        ADC_req_o <= 1'b0;
                        busy_o    <= 1'b0;
                    end else if (to_count == TO_LAST) begin
                        state     <= ST_WAIT_TICK;
                        ADC_req_o <= 1'b0;
                        busy_o    <= 1'b0;
                    end else begin
                        to_count <= to_count + TO_BITS'(1);
                    end
                end
                ST_PID_START: begin
                    state        <= ST_PID_RUN;
                    clk_en_PID_o <= 1'b0;
                end
                ST_PID_RUN: begin
                    if (PID_done_i) begin
                        state  <= enable_i ? ST_WAIT_TICK : ST_IDLE;
                        busy_o <= 1'b0;
                    end
                end
                default: begin
                    state        <= ST_IDLE;
                    ADC_req_o    <= 1'b0;
                    clk_en_PID_o <= 1'b0;
                    busy_o       <= 1'b0;
                end
            endcase
        end
    end

    // Shadow contents including this cycle's write, so a same-cycle commit
    // copies the freshly written value.
    always_comb begin
        shadow_next = shadow;
        if (coeff_wr_i) begin
            for (int unsigned i = 0; i < NUM_COEFFS; i++) begin
                if (coeff_sel_i == COEFF_SEL_BITS'(i)) shadow_next[i] = coeff_data_i;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < NUM_COEFFS; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
            pending <= 1'b0;
        end else begin
            shadow <= shadow_next;
            if ((pending || coeff_commit_i) && commit_window) begin
                active  <= shadow_next;
                pending <= 1'b0;
            end else if (coeff_commit_i) begin
                pending <= 1'b1;
            end
        end
    end

    assign a1_reg_o = active[COEFF_A1];
    assign a0_reg_o = active[COEFF_A0];
    assign b0_reg_o = active[COEFF_B0];
    assign b1_reg_o = active[COEFF_B1];
    assign b2_reg_o = active[COEFF_B2];

endmodule

// File: tb/tb_pid_sample_sequencer.sv
// Directed self-checking bench for pid_sample_sequencer with a short sample
// period (20) and ADC timeout (8).
module tb_pid_sample_sequencer;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        enable_i = 1'b0;
    logic        ADC_req_o;
    logic        ADC_ack_i = 1'b0;
    logic [7:0]  ADC_data_i = '0;
    logic [7:0]  ADC_value_o;
    logic        clk_en_PID_o;
    logic        PID_done_i = 1'b0;
    logic        coeff_wr_i = 1'b0;
    logic [2:0]  coeff_sel_i = '0;
    logic [31:0] coeff_data_i = '0;
    logic        coeff_commit_i = 1'b0;
    logic [31:0] a1_reg_o, a0_reg_o, b0_reg_o, b1_reg_o, b2_reg_o;
    logic        busy_o, overrun_o, timeout_o;
    logic        clear_flags_i = 1'b0;

    int unsigned checks = 0;
    int unsigned errors = 0;

    pid_sample_sequencer #(
        .ADC_BITWIDTH    (8),
        .REG_BITWIDTH    (32),
        .PERIOD_BITWIDTH (16),
        .SAMPLE_PERIOD   (20),
        .ADC_TIMEOUT     (8)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .enable_i       (enable_i),
        .ADC_req_o      (ADC_req_o),
        .ADC_ack_i      (ADC_ack_i),
        .ADC_data_i     (ADC_data_i),
        .ADC_value_o    (ADC_value_o),
        .clk_en_PID_o   (clk_en_PID_o),
        .PID_done_i     (PID_done_i),
        .coeff_wr_i     (coeff_wr_i),
        .coeff_sel_i    (coeff_sel_i),
        .coeff_data_i   (coeff_data_i),
        .coeff_commit_i (coeff_commit_i),
        .a1_reg_o       (a1_reg_o),
        .a0_reg_o       (a0_reg_o),
        .b0_reg_o       (b0_reg_o),
        .b1_reg_o       (b1_reg_o),
        .b2_reg_o       (b2_reg_o),
        .busy_o         (busy_o),
        .overrun_o      (overrun_o),
        .timeout_o      (timeout_o),
        .clear_flags_i  (clear_flags_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled and inputs driven 1 ns after the edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    int unsigned n;
    int unsigned pulses;

    initial begin
        // Reset state
        #3;
        check_eq("rst_req", ADC_req_o, 0);
        check_eq("rst_clk_en", clk_en_PID_o, 0);
        check_eq("rst_busy", busy_o, 0);
        check_eq("rst_value", ADC_value_o, 0);
        check_eq("rst_flags", {overrun_o, timeout_o}, 0);
        check_eq("rst_a1", a1_reg_o, 0);
        step();
        rst_i = 1'b0;
        step();

        // Disabled: nothing happens
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (ADC_req_o || busy_o) pulses++;
        end
        check_eq("disabled_idle", pulses, 0);

        // Test 1: tick latency (enable driven now, first seen at next edge)
        enable_i = 1'b1;
        n = 0;
        while (!ADC_req_o && n < 100) begin
            step();
            n++;
        end
        check_eq("req_latency", n, 21);
        check_eq("busy_in_req", busy_o, 1);

        // Test 2/4/5: ack, one clk_en pulse, long PID run, commit while running
        ADC_ack_i = 1'b1;
        ADC_data_i = 8'h5A;
        step();
        ADC_ack_i = 1'b0;
        ADC_data_i = 8'h00;
        check_eq("ack_value", ADC_value_o, 8'h5A);
        check_eq("ack_clk_en", clk_en_PID_o, 1);
        check_eq("ack_req_drop", ADC_req_o, 0);
        pulses = 1;
        n = 0;
        for (int i = 0; i < 29; i++) begin
            if (i == 5) begin
                coeff_wr_i = 1'b1;
                coeff_sel_i = 3'd2;
                coeff_data_i = 32'h4000_0000;
                coeff_commit_i = 1'b1;
            end
            step();
            coeff_wr_i = 1'b0;
            coeff_commit_i = 1'b0;
            if (clk_en_PID_o) pulses++;
            if (b0_reg_o != 32'h0) n++;
        end
        check_eq("b0_held_in_run", n, 0);
        check_eq("busy_in_run", busy_o, 1);
        check_eq("overrun_set", overrun_o, 1);
        PID_done_i = 1'b1;
        step();
        PID_done_i = 1'b0;
        check_eq("done_busy", busy_o, 0);
        check_eq("one_clk_en", pulses, 1);
        check_eq("b0_at_done", b0_reg_o, 0);
        step();
        check_eq("b0_after_done", b0_reg_o, 32'h4000_0000);
        clear_flags_i = 1'b1;
        step();
        clear_flags_i = 1'b0;
        check_eq("overrun_clear", overrun_o, 0);

        // Test 3: ADC never acks
        n = 0;
        while (!ADC_req_o && n < 40) begin
            step();
            n++;
        end
        check_eq("req_rise_2", ADC_req_o, 1);
        n = 0;
        pulses = 0;
        while (ADC_req_o && n < 50) begin
            step();
            n++;
            if (clk_en_PID_o) pulses++;
        end
        check_eq("req_high_cycles", n, 8);
        check_eq("timeout_set", timeout_o, 1);
        check_eq("timeout_no_clk_en", pulses, 0);
        check_eq("timeout_value_kept", ADC_value_o, 8'h5A);
        check_eq("timeout_busy", busy_o, 0);
        clear_flags_i = 1'b1;
        step();
        clear_flags_i = 1'b0;
        check_eq("timeout_clear", timeout_o, 0);

        // Ack in the same cycle the timeout would fire: ack wins
        n = 0;
        while (!ADC_req_o && n < 40) begin
            step();
            n++;
        end
        check_eq("req_rise_3", ADC_req_o, 1);
        for (int i = 0; i < 7; i++) step();
        ADC_ack_i = 1'b1;
        ADC_data_i = 8'hC3;
        step();
        ADC_ack_i = 1'b0;
        check_eq("late_ack_value", ADC_value_o, 8'hC3);
        check_eq("late_ack_clk_en", clk_en_PID_o, 1);
        check_eq("late_ack_no_timeout", timeout_o, 0);
        step();
        PID_done_i = 1'b1;
        step();
        PID_done_i = 1'b0;
        check_eq("late_done_busy", busy_o, 0);

        // Write + commit same cycle in WAIT_TICK
        coeff_wr_i = 1'b1;
        coeff_sel_i = 3'd0;
        coeff_data_i = 32'h1234_5678;
        coeff_commit_i = 1'b1;
        step();
        check_eq("a1_same_cycle", a1_reg_o, 32'h1234_5678);
        // Out-of-range select is ignored
        coeff_sel_i = 3'd5;
        coeff_data_i = 32'hFFFF_FFFF;
        step();
        check_eq("sel5_a1", a1_reg_o, 32'h1234_5678);
        check_eq("sel5_b2", b2_reg_o, 0);
        // Write without commit leaves active alone
        coeff_commit_i = 1'b0;
        coeff_sel_i = 3'd4;
        coeff_data_i = 32'h0000_ABCD;
        step();
        coeff_wr_i = 1'b0;
        check_eq("b2_no_commit", b2_reg_o, 0);
        coeff_commit_i = 1'b1;
        step();
        coeff_commit_i = 1'b0;
        check_eq("b2_commit", b2_reg_o, 32'h0000_ABCD);
        check_eq("b0_kept", b0_reg_o, 32'h4000_0000);

        // Test 6: asynchronous reset mid-cycle during ADC_REQ
        n = 0;
        while (!ADC_req_o && n < 40) begin
            step();
            n++;
        end
        check_eq("req_rise_4", ADC_req_o, 1);
        #2;
        rst_i = 1'b1;
        #1;
        check_eq("arst_req", ADC_req_o, 0);
        check_eq("arst_busy", busy_o, 0);
        check_eq("arst_a1", a1_reg_o, 0);
        check_eq("arst_b0", b0_reg_o, 0);
        check_eq("arst_b2", b2_reg_o, 0);
        check_eq("arst_value", ADC_value_o, 0);
        step();
        rst_i = 1'b0;
        n = 0;
        while (!ADC_req_o && n < 100) begin
            step();
            n++;
        end
        check_eq("post_rst_latency", n, 21);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
